// File: rtl/adc_acq_pkg.sv
// rtl/adc_acq_pkg.sv - shared state encoding and stored-word layout for the ADC acquisition sequencer
package adc_acq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WARMUP  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_DONE    = 3'd4
  } acq_state_e;

  localparam int ACQ_WORD_W = 16;
  localparam int SAMPLE_LSB = 0;
  localparam int SAMPLE_W   = 12;
  localparam int OTR_BIT    = 12;

  function automatic logic [ACQ_WORD_W-1:0] pack_word(input logic [SAMPLE_W-1:0] sample,
                                                      input logic              tag);
    logic [ACQ_WORD_W-1:0] w;
    w                           = '0;
    w[SAMPLE_LSB +: SAMPLE_W]   = sample;
    w[OTR_BIT]                  = tag;
    return w;
  endfunction

endpackage

// File: rtl/adc_acq_sequencer_if.sv
// rtl/adc_acq_sequencer_if.sv - burst handshake between the acquisition sequencer and the PSRAM write path
interface adc_acq_sequencer_if #(
  parameter int ADDR_W = 22
);
  import adc_acq_pkg::*;

  logic                  burst_req;
  logic [ADDR_W-1:0]     burst_addr;
  logic                  burst_ack;
  logic                  burst_rd;
  logic [ACQ_WORD_W-1:0] burst_data;

  modport master (
    output burst_req,
    output burst_addr,
    output burst_data,
    input  burst_ack,
    input  burst_rd
  );

  modport slave (
    input  burst_req,
    input  burst_addr,
    input  burst_data,
    output burst_ack,
    output burst_rd
  );

endinterface

// File: rtl/acq_pingpong_buf.sv
// rtl/acq_pingpong_buf.sv - two-bank burst buffer with fill/drain pointers and per-bank full flags
module acq_pingpong_buf
  import adc_acq_pkg::*;
#(
  parameter int BURST_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [ACQ_WORD_W-1:0] wr_data,
  input  logic                  rd_en,
  output logic                  wr_ok,
  output logic                  wr_drop,
  output logic                  drain_full,
  output logic                  any_full,
  output logic                  rd_last,
  output logic [ACQ_WORD_W-1:0] rd_data
);

  localparam int            PW   = $clog2(BURST_LEN);
  localparam logic [PW-1:0] LAST = PW'(BURST_LEN - 1);

  logic [ACQ_WORD_W-1:0] mem_q [2][BURST_LEN];

  logic          fill_sel_q,  fill_sel_d;
  logic          drain_sel_q, drain_sel_d;
  logic [PW-1:0] fill_ptr_q,  fill_ptr_d;
  logic [PW-1:0] rd_ptr_q,    rd_ptr_d;
  logic [1:0]    full_q,      full_d;
  logic          wr_last;
  logic          free_into_fill;

  // Fill and drain both alternate 0,1,0,1 so a full fill bank always means both banks are full.
  always_comb begin
    rd_last        = rd_en && (rd_ptr_q == LAST);
    free_into_fill = rd_last && (drain_sel_q == fill_sel_q);
    wr_ok          = wr_en && (!full_q[fill_sel_q] || free_into_fill);
    wr_drop        = wr_en && !wr_ok;
    wr_last        = wr_ok && (fill_ptr_q == LAST);

    full_d      = full_q;
    fill_ptr_d  = fill_ptr_q;
    fill_sel_d  = fill_sel_q;
    rd_ptr_d    = rd_ptr_q;
    drain_sel_d = drain_sel_q;

    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (rd_last) begin
      full_d[drain_sel_q] = 1'b0;
      drain_sel_d         = ~drain_sel_q;
    end
    if (wr_ok) begin
      fill_ptr_d = fill_ptr_q + PW'(1);
    end
    if (wr_last) begin
      full_d[fill_sel_q] = 1'b1;
      fill_sel_d         = ~fill_sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      full_q      <= '0;
      fill_ptr_q  <= '0;
      fill_sel_q  <= 1'b0;
      rd_ptr_q    <= '0;
      drain_sel_q <= 1'b0;
    end else begin
      full_q      <= full_d;
      fill_ptr_q  <= fill_ptr_d;
      fill_sel_q  <= fill_sel_d;
      rd_ptr_q    <= rd_ptr_d;
      drain_sel_q <= drain_sel_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[fill_sel_q][fill_ptr_q] <= wr_data;
    end
  end

  assign drain_full = full_q[drain_sel_q];
  assign any_full   = |full_q;
  assign rd_data    = mem_q[drain_sel_q][rd_ptr_q];

endmodule

// File: rtl/adc_acq_sequencer.sv
// rtl/adc_acq_sequencer.sv - ADC acquisition run sequencer feeding PSRAM bursts
// Optional OTR tagging of stored words and the otr_seen output: define ACQ_OTR_TAG_EN.
module adc_acq_sequencer
  import adc_acq_pkg::*;
#(
  parameter int ACQ_LEN   = 1024,
  parameter int BURST_LEN = 16,
  parameter int WARMUP    = 8,
  parameter int ADDR_W    = 22,
  parameter int BASE_ADDR = 0
) (
  input  logic        clk_PSRAM,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        sample_strobe,
  input  logic [11:0] adc_data,
  input  logic        adc_OTR,
  output logic        adc_enable,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic [15:0] sample_count,
`ifdef ACQ_OTR_TAG_EN
  output logic        otr_seen,
`endif
  adc_acq_sequencer_if.master bif
);

  localparam logic [15:0]       ACQ_LEN_C = 16'(ACQ_LEN);
  localparam logic [15:0]       WARM_LAST = 16'(WARMUP - 1);
  localparam logic [ADDR_W-1:0] BASE_C    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP_C    = ADDR_W'(BURST_LEN);

  acq_state_e        state_q, state_d;
  logic [15:0]       warm_cnt_q, warm_cnt_d;
  logic [15:0]       sample_count_q, sample_count_d;
  logic              overrun_q, overrun_d;
  logic              active_q, active_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              otr_seen_q, otr_seen_d;

  logic                  buf_clear;
  logic                  buf_wr_en;
  logic                  buf_rd_en;
  logic [ACQ_WORD_W-1:0] buf_wr_data;
  logic                  wr_ok;
  logic                  wr_drop;
  logic                  drain_full;
  logic                  any_full;
  logic                  rd_last;
  logic [ACQ_WORD_W-1:0] rd_data;
  logic                  burst_req;
  logic                  sample_tag;

`ifdef ACQ_OTR_TAG_EN
  assign sample_tag = adc_OTR;
  assign otr_seen   = otr_seen_q;
`else
  logic unused_otr;
  assign sample_tag = 1'b0;
  assign unused_otr = adc_OTR ^ otr_seen_q;
`endif

  assign buf_wr_data = pack_word(adc_data, sample_tag);
  assign burst_req   = drain_full && !active_q;

  acq_pingpong_buf #(
    .BURST_LEN (BURST_LEN)
  ) u_buf (
    .clk        (clk_PSRAM),
    .rst        (rst),
    .clear      (buf_clear),
    .wr_en      (buf_wr_en),
    .wr_data    (buf_wr_data),
    .rd_en      (buf_rd_en),
    .wr_ok      (wr_ok),
    .wr_drop    (wr_drop),
    .drain_full (drain_full),
    .any_full   (any_full),
    .rd_last    (rd_last),
    .rd_data    (rd_data)
  );

  always_comb begin
    state_d        = state_q;
    warm_cnt_d     = warm_cnt_q;
    sample_count_d = sample_count_q;
    overrun_d      = overrun_q;
    active_d       = active_q;
    addr_d         = addr_q;
    otr_seen_d     = otr_seen_q;
    buf_clear      = 1'b0;
    buf_wr_en      = (state_q == ST_CAPTURE) && sample_strobe && !abort;
    // An rd in the ack cycle is dropped because active_q is still low then.
    buf_rd_en      = active_q && bif.burst_rd && !abort;

    if (burst_req && bif.burst_ack) begin
      active_d = 1'b1;
    end
    if (rd_last) begin
      active_d = 1'b0;
      addr_d   = addr_q + STEP_C;
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d        = ST_WARMUP;
          warm_cnt_d     = '0;
          sample_count_d = '0;
          overrun_d      = 1'b0;
          active_d       = 1'b0;
          addr_d         = BASE_C;
          otr_seen_d     = 1'b0;
          buf_clear      = 1'b1;
        end
      end
      ST_WARMUP: begin
        if (sample_strobe) begin
          if (warm_cnt_q == WARM_LAST) begin
            state_d = ST_CAPTURE;
          end else begin
            warm_cnt_d = warm_cnt_q + 16'd1;
          end
        end
      end
      ST_CAPTURE: begin
        if (wr_ok) begin
          sample_count_d = sample_count_q + 16'd1;
          if (sample_tag) begin
            otr_seen_d = 1'b1;
          end
          if (sample_count_q + 16'd1 == ACQ_LEN_C) begin
            state_d = ST_FLUSH;
          end
        end
        if (wr_drop) begin
          overrun_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (!any_full && !active_q) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d   = ST_IDLE;
      active_d  = 1'b0;
      buf_clear = 1'b1;
    end
  end

  always_ff @(posedge clk_PSRAM) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      warm_cnt_q     <= '0;
      sample_count_q <= '0;
      overrun_q      <= 1'b0;
      active_q       <= 1'b0;
      addr_q         <= BASE_C;
      otr_seen_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      warm_cnt_q     <= warm_cnt_d;
      sample_count_q <= sample_count_d;
      overrun_q      <= overrun_d;
      active_q       <= active_d;
      addr_q         <= addr_d;
      otr_seen_q     <= otr_seen_d;
    end
  end

  assign adc_enable     = (state_q == ST_WARMUP) || (state_q == ST_CAPTURE);
  assign busy           = (state_q == ST_WARMUP) || (state_q == ST_CAPTURE) || (state_q == ST_FLUSH);
  assign done           = (state_q == ST_DONE);
  assign overrun        = overrun_q;
  assign sample_count   = sample_count_q;
  assign bif.burst_req  = burst_req;
  assign bif.burst_addr = addr_q;
  assign bif.burst_data = rd_data;

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// tb/tb_adc_acq_sequencer.sv - directed self-checking bench for adc_acq_sequencer
module tb_adc_acq_sequencer;

  localparam int ACQ_LEN   = 64;
  localparam int BURST_LEN = 16;
  localparam int WARMUP    = 8;
  localparam int ADDR_W    = 5;
  localparam int BASE_ADDR = 16;
`ifdef ACQ_OTR_TAG_EN
  localparam logic TAG_EN = 1'b1;
`else
  localparam logic TAG_EN = 1'b0;
`endif

  logic        clk_PSRAM = 1'b0;
  logic        rst, start, abort, sample_strobe, adc_OTR;
  logic [11:0] adc_data;
  logic        adc_enable, busy, done, overrun;
  logic [15:0] sample_count;
`ifdef ACQ_OTR_TAG_EN
  logic        otr_seen;
`endif

  int checks = 0;
  int errors = 0;

  adc_acq_sequencer_if #(.ADDR_W(ADDR_W)) bif ();

  adc_acq_sequencer #(
    .ACQ_LEN   (ACQ_LEN),
    .BURST_LEN (BURST_LEN),
    .WARMUP    (WARMUP),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk_PSRAM     (clk_PSRAM),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .sample_strobe (sample_strobe),
    .adc_data      (adc_data),
    .adc_OTR       (adc_OTR),
    .adc_enable    (adc_enable),
    .busy          (busy),
    .done          (done),
    .overrun       (overrun),
    .sample_count  (sample_count),
`ifdef ACQ_OTR_TAG_EN
    .otr_seen      (otr_seen),
`endif
    .bif           (bif)
  );

  always #5 clk_PSRAM = ~clk_PSRAM;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_PSRAM);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [11:0] d, input logic tag);
    return {16'h0000, 3'b000, tag & TAG_EN, d};
  endfunction

  task automatic strobe(input logic [11:0] d, input logic otr);
    sample_strobe = 1'b1;
    adc_data      = d;
    adc_OTR       = otr;
    tick();
    sample_strobe = 1'b0;
    adc_OTR       = 1'b0;
    tick();
  endtask

  task automatic warmup();
    repeat (WARMUP) strobe(12'hFFF, 1'b1);
    chk("warmup_discard", 32'(sample_count), 0);
  endtask

  task automatic fill(input logic [11:0] base, input int otr_idx);
    for (int i = 0; i < BURST_LEN; i++) strobe(base + 12'(i), i == otr_idx);
  endtask

  task automatic wait_req(input string tag, input int addr);
    int n;
    n = 0;
    while (bif.burst_req !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, 32'(bif.burst_req), 1);
    chk({tag, "_addr"}, 32'(bif.burst_addr), 32'(addr));
    repeat (2) tick();
    bif.burst_ack = 1'b1;
    bif.burst_rd  = 1'b1;
    tick();
    bif.burst_ack = 1'b0;
    chk({tag, "_ack_clears_req"}, 32'(bif.burst_req), 0);
  endtask

  task automatic read_words(input string tag, input logic [11:0] base, input int otr_idx, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_w%0d", tag, i), 32'(bif.burst_data), exp_word(base + 12'(i), i == otr_idx));
      bif.burst_rd = 1'b1;
      tick();
    end
    bif.burst_rd = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; sample_strobe = 1'b0;
    adc_data = '0; adc_OTR = 1'b0; bif.burst_ack = 1'b0; bif.burst_rd = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_enable", 32'(adc_enable), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_req", 32'(bif.burst_req), 0);
    chk("rst_addr", 32'(bif.burst_addr), BASE_ADDR);
    chk("rst_count", 32'(sample_count), 0);

    // nominal run: four bursts, address 16 -> 0 -> 16 -> 0 wrapping in 5 bits
    start = 1'b1; tick(); start = 1'b0;
    chk("start_enable", 32'(adc_enable), 1);
    chk("start_busy", 32'(busy), 1);
    chk("start_done", 32'(done), 0);
    warmup();
    for (int b = 0; b < 4; b++) begin
      fill(12'(b * 16), (b == 0) ? 4 : -1);
      chk($sformatf("nom%0d_count", b), 32'(sample_count), (b + 1) * 16);
      if (b == 3) begin
        chk("flush_enable", 32'(adc_enable), 0);
        chk("flush_busy", 32'(busy), 1);
      end
      wait_req($sformatf("nom%0d", b), (b % 2 == 0) ? 16 : 0);
      read_words($sformatf("nom%0d", b), 12'(b * 16), (b == 0) ? 4 : -1, BURST_LEN);
      chk($sformatf("nom%0d_req_idle", b), 32'(bif.burst_req), 0);
      chk($sformatf("nom%0d_next_addr", b), 32'(bif.burst_addr), (b % 2 == 0) ? 0 : 16);
    end
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("nom_done", 32'(done), 1);
    chk("nom_busy", 32'(busy), 0);
    chk("nom_overrun", 32'(overrun), 0);
    chk("nom_count", 32'(sample_count), ACQ_LEN);
`ifdef ACQ_OTR_TAG_EN
    chk("nom_otr_seen", 32'(otr_seen), 1);
`endif

    // second run: fill both banks, free one exactly on a strobe, then overrun
    start = 1'b1; tick(); start = 1'b0;
    chk("run2_count", 32'(sample_count), 0);
    chk("run2_done", 32'(done), 0);
    chk("run2_addr", 32'(bif.burst_addr), BASE_ADDR);
`ifdef ACQ_OTR_TAG_EN
    chk("run2_otr_cleared", 32'(otr_seen), 0);
`endif
    warmup();
    fill(12'h100, -1);
    fill(12'h110, -1);
    chk("both_full_count", 32'(sample_count), 32);
    chk("both_full_overrun", 32'(overrun), 0);
    wait_req("edge", 16);
    for (int i = 0; i < BURST_LEN; i++) begin
      chk($sformatf("edge_w%0d", i), 32'(bif.burst_data), exp_word(12'h100 + 12'(i), 1'b0));
      bif.burst_rd = 1'b1;
      if (i == BURST_LEN - 1) begin
        sample_strobe = 1'b1;
        adc_data      = 12'h0AA;
      end
      tick();
    end
    bif.burst_rd = 1'b0; sample_strobe = 1'b0;
    chk("edge_count", 32'(sample_count), 33);
    chk("edge_overrun", 32'(overrun), 0);
    for (int i = 0; i < 15; i++) strobe(12'h0AB + 12'(i), 1'b0);
    chk("refill_count", 32'(sample_count), 48);
    chk("refill_overrun", 32'(overrun), 0);
    strobe(12'h3C3, 1'b0);
    chk("ovr_flag", 32'(overrun), 1);
    chk("ovr_count", 32'(sample_count), 48);
    repeat (7) strobe(12'h3C4, 1'b0);
    chk("ovr_sticky", 32'(overrun), 1);
    chk("ovr_count_hold", 32'(sample_count), 48);
    chk("ovr_still_enabled", 32'(adc_enable), 1);

    // abort after five words of the second bank's burst
    wait_req("abort", 0);
    read_words("abort", 12'h110, -1, 5);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_req", 32'(bif.burst_req), 0);
    chk("abort_enable", 32'(adc_enable), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_keeps_overrun", 32'(overrun), 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_addr", 32'(bif.burst_addr), BASE_ADDR);
    chk("restart_overrun", 32'(overrun), 0);
    chk("restart_req", 32'(bif.burst_req), 0);
    chk("restart_busy", 32'(busy), 1);
    warmup();
    fill(12'h200, -1);
    wait_req("restart", 16);
    read_words("restart", 12'h200, -1, BURST_LEN);
    chk("restart_next_addr", 32'(bif.burst_addr), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
